// File: rtl/pmips_pkg.sv
// Shared opcodes, sequencer state encoding and source-use decode for the PMIPSL0 hazard logic.
package pmips_pkg;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_BEQ   = 3'd2;
  localparam logic [2:0] OP_ADDI  = 3'd3;
  localparam logic [2:0] OP_LW    = 3'd4;
  localparam logic [2:0] OP_SW    = 3'd5;

  localparam int REG_ZERO = 0;
  // Wide enough for any branch window of 1..15 cycles.
  localparam int TIMER_W  = 4;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_t;

  function automatic logic uses_rs(input logic [2:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW) ||
           (op == OP_ADDI)  || (op == OP_LW);
  endfunction

  function automatic logic uses_rt(input logic [2:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_sequencer_match.sv
// hazard_match: decodes which sources the ID instruction reads and compares them to in-flight destinations.
// HAZ_FORWARD_EN defined: only load-use hazards are flagged (forwarding covers the rest).
module hazard_match
  import pmips_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic              id_valid,
  input  logic [2:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  output logic              hz
);

  logic rs_live;
  logic rt_live;
  logic ex_match;
  logic load_use;

  // Register zero is hard-wired, so a read of it can never depend on a producer.
  assign rs_live = id_valid & uses_rs(id_opcode) & (id_rs != REG_AW'(REG_ZERO));
  assign rt_live = id_valid & uses_rt(id_opcode) & (id_rt != REG_AW'(REG_ZERO));

  assign ex_match = (rs_live & (ex_rd == id_rs)) | (rt_live & (ex_rd == id_rt));
  assign load_use = ex_memread & ex_regwrite & ex_match;

`ifdef HAZ_FORWARD_EN
  logic unused_mem;
  assign unused_mem = ^{mem_regwrite, mem_rd};
  assign hz = load_use;
`else
  logic mem_match;
  assign mem_match = (rs_live & (mem_rd == id_rs)) | (rt_live & (mem_rd == id_rt));
  assign hz = load_use | (ex_regwrite & ex_match) | (mem_regwrite & mem_match);
`endif

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: PMIPSL0 pipeline stall/flush sequencer with BEQ resolution window and stall counter.
// Hazard set depends on HAZ_FORWARD_EN (see hazard_match).
module hazard_sequencer
  import pmips_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int BR_LATENCY = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [2:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              br_resolved,
  input  logic              br_taken,
  output logic              pc_stall,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pc_src,
  output logic              br_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  state_t             state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               br_timeout_reg, br_timeout_next;
  logic [CNT_W-1:0]   stall_cycles_reg;
  logic               hz;

  hazard_match #(.REG_AW(REG_AW)) u_match (
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .hz           (hz)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_RUN;
      timer_reg        <= '0;
      br_timeout_reg   <= 1'b0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      br_timeout_reg <= br_timeout_next;
      if (pc_stall && (stall_cycles_reg != {CNT_W{1'b1}}))
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    br_timeout_next = br_timeout_reg;
    pc_stall        = 1'b0;
    ifid_hold       = 1'b0;
    ifid_flush      = 1'b0;
    idex_bubble     = 1'b0;
    pc_src          = 1'b0;
    case (state_reg)
      ST_RUN: begin
        // A hazard holds the BEQ in ID too, so the window only opens once it is clean.
        if (hz) begin
          pc_stall    = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_valid && (id_opcode == OP_BEQ)) begin
          state_next = ST_BR_WAIT;
          timer_next = TIMER_W'(BR_LATENCY);
        end
      end
      ST_BR_WAIT: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        if (br_resolved) begin
          pc_src     = br_taken;
          state_next = ST_RUN;
          timer_next = '0;
        end else if (timer_reg == TIMER_W'(1)) begin
          br_timeout_next = 1'b1;
          state_next      = ST_RUN;
          timer_next      = '0;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_RUN;
        timer_next = '0;
      end
    endcase
  end

  assign br_timeout   = br_timeout_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: expected controls are queued per step and checked before the next edge.
module tb_hazard_sequencer;
  import pmips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [2:0]  id_opcode;
  logic [2:0]  id_rs, id_rt;
  logic        ex_regwrite, ex_memread;
  logic [2:0]  ex_rd;
  logic        mem_regwrite;
  logic [2:0]  mem_rd;
  logic        br_resolved, br_taken;
  logic        pc_stall, ifid_hold, ifid_flush, idex_bubble, pc_src, br_timeout;
  logic [15:0] stall_cycles;

  hazard_sequencer #(.REG_AW(3), .BR_LATENCY(2), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .br_resolved  (br_resolved),
    .br_taken     (br_taken),
    .pc_stall     (pc_stall),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .pc_src       (pc_src),
    .br_timeout   (br_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  // {pc_stall, ifid_hold, ifid_flush, idex_bubble, pc_src, br_timeout}
  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_HZ     = 6'b110100;
  localparam logic [5:0] C_BRW    = 6'b101000;
  localparam logic [5:0] C_BRT    = 6'b101010;
  localparam logic [5:0] C_TO     = 6'b000001;
  localparam logic [5:0] C_BRW_TO = 6'b101001;
`ifdef HAZ_FORWARD_EN
  localparam logic [5:0] C_RAW    = C_NONE;
`else
  localparam logic [5:0] C_RAW    = C_HZ;
`endif

  typedef struct {
    string       tag;
    logic [5:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  logic [15:0] exp_cnt = '0;

  task automatic set_id(input logic v, input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt;
  endtask

  task automatic set_ex(input logic rw, input logic mr, input logic [2:0] rd);
    ex_regwrite = rw; ex_memread = mr; ex_rd = rd;
  endtask

  task automatic set_mem(input logic rw, input logic [2:0] rd);
    mem_regwrite = rw; mem_rd = rd;
  endtask

  task automatic compare_front();
    exp_t e;
    logic [5:0] obs;
    e   = sb.pop_front();
    obs = {pc_stall, ifid_hold, ifid_flush, idex_bubble, pc_src, br_timeout};
    checks++;
    assert (obs === e.ctl) else begin
      fails++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
    end
    checks++;
    assert (stall_cycles === e.cnt) else begin
      fails++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, stall_cycles, e.cnt);
    end
    $display("step %-14s ctl=%b cnt=%0d", e.tag, obs, stall_cycles);
  endtask

  // Inputs are already applied by the caller at a falling edge; sample 1 ns later.
  task automatic step(input string tag, input logic [5:0] ctl);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.cnt = exp_cnt;
    sb.push_back(e);
    #1;
    compare_front();
    if (ctl[5] && exp_cnt != 16'hFFFF) exp_cnt++;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    set_id(0, OP_RTYPE, 0, 0);
    set_ex(0, 0, 0);
    set_mem(0, 0);
    br_resolved = 1'b0; br_taken = 1'b0;
    repeat (2) @(negedge clock);
    step("reset", C_NONE);
    reset = 1'b0;
    step("idle", C_NONE);

    // load-use, r0 immunity, source-use decode
    set_ex(1, 1, 1); set_id(1, OP_ADDI, 1, 0); step("lu_addi", C_HZ);
    set_ex(0, 0, 0);                          step("lu_clear", C_NONE);
    set_ex(1, 1, 0); set_id(1, OP_RTYPE, 0, 0); step("r0_nohz", C_NONE);
    set_ex(1, 1, 1); set_id(1, OP_ADDI, 2, 1);  step("addi_rt_unused", C_NONE);
    set_id(1, OP_SW, 2, 1);                     step("lu_sw_rt", C_HZ);
    set_id(0, OP_SW, 2, 1);                     step("invalid_id", C_NONE);

    // non-load producers in EX then MEM
    set_ex(1, 0, 3); set_id(1, OP_RTYPE, 2, 3); step("raw_ex", C_RAW);
    set_ex(0, 0, 0); set_mem(1, 3);             step("raw_mem", C_RAW);
    set_mem(0, 0);                              step("raw_done", C_NONE);

    // taken branch; a resolve seen in RUN is ignored
    set_id(1, OP_BEQ, 1, 2); br_resolved = 1'b1; br_taken = 1'b1; step("beq_enter", C_NONE);
    set_id(0, OP_RTYPE, 0, 0); br_resolved = 1'b0;               step("brw_1", C_BRW);
    br_resolved = 1'b1; br_taken = 1'b1;                         step("brw_taken", C_BRT);
    br_resolved = 1'b0; br_taken = 1'b0;                         step("brw_run", C_NONE);

    // hazard outranks BEQ entry, then not-taken resolve
    set_ex(1, 1, 1); set_id(1, OP_BEQ, 1, 2); step("beq_hz", C_HZ);
    set_ex(0, 0, 0);                          step("beq_enter2", C_NONE);
    set_id(0, OP_RTYPE, 0, 0); br_resolved = 1'b1; br_taken = 1'b0; step("brw_nt", C_BRW);
    br_resolved = 1'b0;                       step("brw_nt_run", C_NONE);

    // window expiry, sticky timeout
    set_id(1, OP_BEQ, 0, 0); step("beq_enter3", C_NONE);
    set_id(0, OP_RTYPE, 0, 0); step("to_w1", C_BRW);
    step("to_w2", C_BRW);
    step("to_run", C_TO);
    br_resolved = 1'b1; br_taken = 1'b1; step("to_sticky", C_TO);
    br_resolved = 1'b0; br_taken = 1'b0;

    // reset asserted inside the branch window
    set_id(1, OP_BEQ, 0, 0); step("beq_enter4", C_TO);
    set_id(0, OP_RTYPE, 0, 0); step("rst_w1", C_BRW_TO);
    reset = 1'b1; exp_cnt = '0;
    step("rst_async", C_NONE);
    reset = 1'b0;
    step("rst_run", C_NONE);
    set_ex(1, 1, 1); set_id(1, OP_ADDI, 1, 0); step("post_rst_hz", C_HZ);
    set_ex(0, 0, 0); set_id(0, OP_RTYPE, 0, 0); step("final", C_NONE);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
